// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared widths, mode encodings and FSM state type for the copy engine
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_copy_engine.sv
// ============================================================================
// Module : mem_copy_engine
// Brief  : Block copy/fill sequencer that owns the data-memory port while busy
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_engine #(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int ADDR_W = mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_pkg::*;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_mode;
    logic [DATA_W-1:0] r_fill_val;
    logic [DATA_W-1:0] r_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Port outputs decode from state alone, so the idle port is all-zero
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        mem_addr     = '0;
        mem_wr_en    = 1'b0;
        mem_wdata    = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_next_state = DONE;
                    end else if (mode == MODE_FILL) begin
                        w_next_state = WR;
                    end else begin
                        w_next_state = RD;
                    end
                end
            end
            RD: begin
                busy         = 1'b1;
                mem_addr     = r_src_ptr;
                w_next_state = WR;
            end
            WR: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = r_dst_ptr;
                mem_wdata = (r_mode == MODE_FILL) ? r_fill_val : r_buf;
                if (r_cnt == ADDR_W'(1)) begin
                    w_next_state = DONE;
                end else if (r_mode == MODE_FILL) begin
                    w_next_state = WR;
                end else begin
                    w_next_state = RD;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_ptr  <= '0;
            r_dst_ptr  <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_fill_val <= '0;
            r_buf      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src_ptr  <= src_addr;
                        r_dst_ptr  <= dst_addr;
                        r_cnt      <= len;
                        r_mode     <= mode;
                        r_fill_val <= fill_val;
                    end
                end
                RD: r_buf <= mem_rdata;
                WR: begin
                    // Pointers wrap naturally at the address width
                    r_src_ptr <= r_src_ptr + ADDR_W'(1);
                    r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
                    r_cnt     <= r_cnt - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// Module : tb_mem_copy_engine
// Brief  : Self-checking bench: 16-byte aliased memory plus transfer-level model
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] src_addr, dst_addr, len, fill_val;
    logic       busy, done, mem_wr_en;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] ram [16];
    logic [7:0] model_mem [16];
    logic       pre_we = 1'b0;
    logic [3:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    logic       chk_en = 1'b0;
    exp_t       q [$];
    logic [7:0] waddr [$];
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_val  (fill_val),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[3:0]];

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_wr_en) ram[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transfer-level model: on an accepted start, expand the whole transfer
    // into the per-cycle port activity it must produce.
    always @(posedge clk) begin
        logic [7:0] tmp [16];
        logic [7:0] s, d, dat;
        if (pre_we) model_mem[pre_addr] = pre_data;
        if (reset) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (start) begin
                tmp = model_mem;
                for (int i = 0; i < int'(len); i++) begin
                    s = src_addr + 8'(i);
                    d = dst_addr + 8'(i);
                    if (mode == 1'b0) begin
                        q.push_back('{1'b1, 1'b0, 1'b0, s, 8'h00});
                        dat = tmp[s[3:0]];
                    end else begin
                        dat = fill_val;
                    end
                    tmp[d[3:0]] = dat;
                    q.push_back('{1'b1, 1'b0, 1'b1, d, dat});
                end
                q.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
            end
        end else begin
            if (q[0].wr) model_mem[q[0].addr[3:0]] = q[0].wdata;
            void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = (q.size() != 0) ? q[0] : '0;
            check("port", {13'd0, busy, done, mem_wr_en, mem_addr, mem_wdata}, {13'd0, e});
        end
    end

    task automatic preload(input logic [3:0] a, input logic [7:0] v);
        pre_addr = a;
        pre_data = v;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue one transfer and follow it to done. poke>0 raises a foreign start
    // in that cycle; noise scrambles all request inputs while busy.
    task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] l, input logic [7:0] f, input int poke,
                       input bit noise, output int lat, output int nwr, output int nbusy);
        waddr.delete();
        mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; nwr = 0; nbusy = 0;
        for (int i = 1; i <= 700; i++) begin
            @(negedge clk);
            if (mem_wr_en) begin
                nwr++;
                waddr.push_back(mem_addr);
            end
            if (busy) nbusy++;
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
            if (i == poke) begin
                start = 1'b1; mode = 1'b1; dst_addr = 8'h55; len = 8'd7; fill_val = 8'hEE;
            end else if (i == poke + 1) begin
                start = 1'b0;
            end
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                mode     = 1'($urandom_range(0, 1));
                src_addr = 8'($urandom);
                dst_addr = 8'($urandom);
                len      = 8'($urandom);
                fill_val = 8'($urandom);
            end
        end
        start = 1'b0;
        if (lat < 0) check("timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, nwr, nbusy;
        logic [7:0] snap [16];
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) preload(4'(i), 8'(i));
        reset = 1'b0;
        chk_en = 1'b1;

        run(1'b0, 8'd0, 8'd8, 8'd2, 8'h00, 0, 1'b0, lat, nwr, nbusy);
        check("copy_lat", 32'(lat), 32'd5);
        check("copy_nwr", 32'(nwr), 32'd2);
        check("copy_m8", {24'd0, ram[8]}, 32'h00);
        check("copy_m9", {24'd0, ram[9]}, 32'h01);

        snap = model_mem;
        run(1'b1, 8'd0, 8'd4, 8'd3, 8'hA5, 0, 1'b0, lat, nwr, nbusy);
        check("fill_lat", 32'(lat), 32'd4);
        check("fill_busy", 32'(nbusy), 32'd3);
        check("fill_m4", {24'd0, ram[4]}, 32'hA5);
        check("fill_m6", {24'd0, ram[6]}, 32'hA5);
        check("fill_m3", {24'd0, ram[3]}, {24'd0, snap[3]});
        check("fill_m7", {24'd0, ram[7]}, {24'd0, snap[7]});

        run(1'b0, 8'd1, 8'd2, 8'd0, 8'h00, 0, 1'b0, lat, nwr, nbusy);
        check("len0_lat", 32'(lat), 32'd1);
        check("len0_nwr", 32'(nwr), 32'd0);
        check("len0_busy", 32'(nbusy), 32'd0);

        run(1'b1, 8'd0, 8'hFE, 8'd3, 8'h3C, 2, 1'b0, lat, nwr, nbusy);
        check("wrap_lat", 32'(lat), 32'd4);
        check("wrap_nwr", 32'(nwr), 32'd3);
        if (waddr.size() == 3)
            check("wrap_addrs", {8'd0, waddr[0], waddr[1], waddr[2]}, 32'h00FEFF00);
        else
            check("wrap_addr_cnt", 32'(waddr.size()), 32'd3);
        check("wrap_m14", {24'd0, ram[14]}, 32'h3C);
        check("wrap_m15", {24'd0, ram[15]}, 32'h3C);
        check("wrap_m0", {24'd0, ram[0]}, 32'h3C);
        repeat (4) @(negedge clk) check("wrap_no_late_start", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        preload(4'd2, 8'h11);
        preload(4'd3, 8'h22);
        run(1'b0, 8'd2, 8'd3, 8'd2, 8'h00, 0, 1'b0, lat, nwr, nbusy);
        check("ovl_m3", {24'd0, ram[3]}, 32'h11);
        check("ovl_m4", {24'd0, ram[4]}, 32'h11);

        snap = model_mem;
        mode = 1'b0; src_addr = 8'd0; dst_addr = 8'd10; len = 8'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", {13'd0, busy, done, mem_wr_en, mem_addr, mem_wdata}, 32'd0);
        repeat (6) @(negedge clk) check("rst_no_done", {31'd0, done}, 32'd0);
        check("rst_m10", {24'd0, ram[10]}, {24'd0, snap[0]});
        check("rst_m11", {24'd0, ram[11]}, {24'd0, snap[11]});
        check("rst_m12", {24'd0, ram[12]}, {24'd0, snap[12]});
        check("rst_m13", {24'd0, ram[13]}, {24'd0, snap[13]});
        @(posedge clk);
        #1;

        for (int t = 0; t < 40; t++) begin
            logic       m;
            logic [7:0] l;
            m = 1'($urandom_range(0, 1));
            l = 8'($urandom_range(0, 10));
            if (t == 39) l = 8'd20;
            run(m, 8'($urandom), 8'($urandom), l, 8'($urandom), 0, 1'($urandom_range(0, 1)),
                lat, nwr, nbusy);
            check("rnd_lat", 32'(lat), (l == 0) ? 32'd1 : (m ? 32'(l) + 1 : 2 * 32'(l) + 1));
            check("rnd_nwr", 32'(nwr), 32'(l));
            check("rnd_busy", 32'(nbusy), m ? 32'(l) : 2 * 32'(l));
        end

        for (int i = 0; i < 16; i++) check("final_mem", {24'd0, ram[i]}, {24'd0, model_mem[i]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
